// File: rtl/shift_sequencer.sv
// shift_sequencer: command-driven controller for an external 8-bit shift
// register with parallel load. Each command optionally clears or loads the
// register, shifts it a programmed number of cycles, then captures Q into
// a result register. While idle the shifter is made to reload its own Q so
// its contents are held between commands.
module shift_sequencer (
   input  logic       clock,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_clear,
   input  logic       cmd_load,
   input  logic [7:0] cmd_data,
   input  logic       cmd_dir,
   input  logic       cmd_asr,
   input  logic [2:0] cmd_count,
   output logic       busy,
   output logic [7:0] result,
   output logic       result_valid,
   output logic       sh_reset_n,
   output logic       sh_load_n,
   output logic       sh_left,
   output logic       sh_asr,
   output logic [7:0] sh_data,
   input  logic [7:0] sh_q
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      LOAD    = 3'd2,
      SHIFT   = 3'd3,
      CAPTURE = 3'd4
   } state_t;

   state_t     state_reg;
   logic       dir_reg;
   logic       asr_reg;
   logic [2:0] count_reg;
   logic [7:0] data_reg;
   logic [7:0] result_reg;
   logic       result_valid_reg;

   // Command sequencing: latch the command at accept, then walk
   // clear/load -> shift (count_reg doubles as the shift down-counter) -> capture.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg        <= IDLE;
         dir_reg          <= 1'b0;
         asr_reg          <= 1'b0;
         count_reg        <= 3'd0;
         data_reg         <= 8'h00;
         result_reg       <= 8'h00;
         result_valid_reg <= 1'b0;
      end else begin
         result_valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (cmd_valid) begin
                  dir_reg   <= cmd_dir;
                  asr_reg   <= cmd_asr;
                  count_reg <= cmd_count;
                  data_reg  <= cmd_data;
                  if (cmd_clear)
                     state_reg <= CLEAR;
                  else if (cmd_load)
                     state_reg <= LOAD;
                  else if (cmd_count != 3'd0)
                     state_reg <= SHIFT;
                  else
                     state_reg <= CAPTURE;
               end
            end
            CLEAR: begin
               state_reg <= CAPTURE;
            end
            LOAD: begin
               state_reg <= (count_reg != 3'd0) ? SHIFT : CAPTURE;
            end
            SHIFT: begin
               count_reg <= count_reg - 3'd1;
               if (count_reg == 3'd1)
                  state_reg <= CAPTURE;
            end
            CAPTURE: begin
               result_reg       <= sh_q;
               result_valid_reg <= 1'b1;
               state_reg        <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // Shifter control decode; reset forces the shifter clear and blocks loads
   // immediately, without waiting for a clock edge.
   always_comb begin
      sh_reset_n = !reset && (state_reg != CLEAR);
      sh_load_n  = reset || (state_reg == SHIFT) || (state_reg == CLEAR);
      sh_left    = (state_reg == SHIFT) && dir_reg;
      sh_asr     = (state_reg == SHIFT) && dir_reg && asr_reg;
      sh_data    = (state_reg == LOAD) ? data_reg : sh_q;
   end

   assign cmd_ready    = (state_reg == IDLE);
   assign busy         = (state_reg != IDLE);
   assign result       = result_reg;
   assign result_valid = result_valid_reg;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed tests of shift_sequencer driving a behavioral
// 8-bit shift register with parallel load.
module tb_shift_sequencer;

   logic       clock;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_clear;
   logic       cmd_load;
   logic [7:0] cmd_data;
   logic       cmd_dir;
   logic       cmd_asr;
   logic [2:0] cmd_count;
   logic       busy;
   logic [7:0] result;
   logic       result_valid;
   logic       sh_reset_n;
   logic       sh_load_n;
   logic       sh_left;
   logic       sh_asr;
   logic [7:0] sh_data;
   logic [7:0] sh_q;

   int tests_run;
   int tests_failed;
   bit watch_ff_load;
   bit ff_load_seen;

   shift_sequencer dut (
      .clock        (clock),
      .reset        (reset),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_clear    (cmd_clear),
      .cmd_load     (cmd_load),
      .cmd_data     (cmd_data),
      .cmd_dir      (cmd_dir),
      .cmd_asr      (cmd_asr),
      .cmd_count    (cmd_count),
      .busy         (busy),
      .result       (result),
      .result_valid (result_valid),
      .sh_reset_n   (sh_reset_n),
      .sh_load_n    (sh_load_n),
      .sh_left      (sh_left),
      .sh_asr       (sh_asr),
      .sh_data      (sh_data),
      .sh_q         (sh_q)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Behavioral shifter: clear, parallel load, shift toward bit0 with
   // arithmetic or rotate fill, or rotate toward bit7.
   always @(posedge clock) begin
      if (!sh_reset_n)
         sh_q <= 8'h00;
      else if (!sh_load_n)
         sh_q <= sh_data;
      else if (sh_left)
         sh_q <= {(sh_asr ? sh_q[7] : sh_q[0]), sh_q[7:1]};
      else
         sh_q <= {sh_q[6:0], sh_q[7]};
   end

   // Flags any parallel load of 0xFF while the clear test is running.
   always @(posedge clock) begin
      if (watch_ff_load && sh_reset_n && !sh_load_n && sh_data == 8'hFF)
         ff_load_seen <= 1'b1;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   // Issue one command from idle and check latency, result, busy and pulse width.
   task automatic run_cmd(input string tag, input logic clr, input logic ld,
                          input logic [7:0] d, input logic dir, input logic asr,
                          input logic [2:0] cnt, input logic [7:0] exp_res,
                          input int exp_lat);
      int lat;
      bit ready_leak;
      check_eq($sformatf("%s_ready", tag), {31'd0, cmd_ready}, 32'd1);
      cmd_clear = clr; cmd_load = ld; cmd_data = d;
      cmd_dir = dir; cmd_asr = asr; cmd_count = cnt;
      cmd_valid = 1'b1;
      @(posedge clock); #1;
      // later changes to command fields must not matter
      cmd_valid = 1'b0;
      cmd_clear = ~clr; cmd_load = ~ld; cmd_data = ~d;
      cmd_dir = ~dir; cmd_asr = ~asr; cmd_count = ~cnt;
      lat = 0;
      ready_leak = 1'b0;
      while (!result_valid && lat < 20) begin
         if (cmd_ready || !busy) ready_leak = 1'b1;
         @(posedge clock); #1;
         lat++;
      end
      check_eq($sformatf("%s_lat", tag), lat, exp_lat);
      check_eq($sformatf("%s_result", tag), {24'd0, result}, {24'd0, exp_res});
      check_eq($sformatf("%s_busy", tag), {31'd0, ready_leak}, 32'd0);
      @(posedge clock); #1;
      check_eq($sformatf("%s_pulse", tag), {31'd0, result_valid}, 32'd0);
      cmd_clear = 1'b0; cmd_load = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      bit flag;
      tests_run = 0;
      tests_failed = 0;
      watch_ff_load = 1'b0;
      ff_load_seen = 1'b0;
      reset = 1'b1;
      cmd_valid = 1'b0; cmd_clear = 1'b0; cmd_load = 1'b0; cmd_data = 8'h00;
      cmd_dir = 1'b0; cmd_asr = 1'b0; cmd_count = 3'd0;

      // reset state
      repeat (2) @(posedge clock);
      #1;
      check_eq("rst_ready", {31'd0, cmd_ready}, 32'd1);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_result", {24'd0, result}, 32'h00);
      check_eq("rst_rv", {31'd0, result_valid}, 32'd0);
      check_eq("rst_load_n", {31'd0, sh_load_n}, 32'd1);
      check_eq("rst_sh_reset_n", {31'd0, sh_reset_n}, 32'd0);
      check_eq("rst_sh_q", {24'd0, sh_q}, 32'h00);
      reset = 1'b0;
      @(posedge clock); #1;

      // load + shift toward bit0, rotate fill
      run_cmd("t1", 1'b0, 1'b1, 8'h81, 1'b1, 1'b0, 3'd1, 8'hC0, 3);

      // load + arithmetic shift, then hold
      run_cmd("t2", 1'b0, 1'b1, 8'h90, 1'b1, 1'b1, 3'd3, 8'hF2, 5);
      flag = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clock); #1;
         if (sh_q != 8'hF2) flag = 1'b1;
      end
      check_eq("t2_hold", {31'd0, flag}, 32'd0);
      check_eq("t2_hold_q", {24'd0, sh_q}, 32'hF2);

      // rotate toward bit7, idle, then no-load rotate by 7
      run_cmd("t3a", 1'b0, 1'b1, 8'h81, 1'b0, 1'b0, 3'd2, 8'h06, 4);
      repeat (5) @(posedge clock);
      #1;
      run_cmd("t3b", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd7, 8'h03, 8);

      // clear overrides load
      watch_ff_load = 1'b1;
      run_cmd("t4", 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 3'd5, 8'h00, 2);
      watch_ff_load = 1'b0;
      check_eq("t4_no_ff_load", {31'd0, ff_load_seen}, 32'd0);

      // back-to-back with cmd_valid held high
      cmd_clear = 1'b0; cmd_load = 1'b1; cmd_data = 8'h81;
      cmd_dir = 1'b1; cmd_asr = 1'b0; cmd_count = 3'd1;
      cmd_valid = 1'b1;
      @(posedge clock); #1;
      cmd_load = 1'b0; cmd_data = 8'h00; cmd_dir = 1'b0; cmd_count = 3'd1;
      lat = 0;
      while (!result_valid && lat < 20) begin
         @(posedge clock); #1;
         lat++;
      end
      check_eq("t5a_lat", lat, 3);
      check_eq("t5a_result", {24'd0, result}, 32'hC0);
      check_eq("t5a_ready_on_rv", {31'd0, cmd_ready}, 32'd1);
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      check_eq("t5b_accepted", {31'd0, cmd_ready}, 32'd0);
      lat = 0;
      while (!result_valid && lat < 20) begin
         @(posedge clock); #1;
         lat++;
      end
      check_eq("t5b_lat", lat, 2);
      check_eq("t5b_result", {24'd0, result}, 32'h81);
      @(posedge clock); #1;

      // reset during a long shift
      cmd_clear = 1'b0; cmd_load = 1'b1; cmd_data = 8'hAA;
      cmd_dir = 1'b0; cmd_asr = 1'b0; cmd_count = 3'd7;
      cmd_valid = 1'b1;
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check_eq("t6_in_shift", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      #1;
      check_eq("t6_ready", {31'd0, cmd_ready}, 32'd1);
      check_eq("t6_busy", {31'd0, busy}, 32'd0);
      check_eq("t6_result", {24'd0, result}, 32'h00);
      check_eq("t6_rv", {31'd0, result_valid}, 32'd0);
      check_eq("t6_load_n", {31'd0, sh_load_n}, 32'd1);
      check_eq("t6_sh_reset_n", {31'd0, sh_reset_n}, 32'd0);
      @(posedge clock); #1;
      check_eq("t6_sh_q", {24'd0, sh_q}, 32'h00);
      reset = 1'b0;
      flag = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (result_valid) flag = 1'b1;
         @(posedge clock); #1;
      end
      check_eq("t6_no_rv", {31'd0, flag}, 32'd0);
      run_cmd("t6b", 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 3'd0, 8'h55, 2);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Command-driven controller for the 8-bit shift register with parallel load (controls: reset_n, parallel_load_n, load_left, ASRight, data_in, Q). Accepts one command at a time over a valid/ready handshake. Each command optionally loads or clears the register, then shifts it a programmed number of cycles, then captures Q into a result register. Between commands it holds the register's contents, which the shifter cannot do on its own.

## Interface
No parameters; width fixed at 8, shift count fixed at 3 bits.
- clock  in  1  system clock, rising edge; shared with the shifter
- reset  in  1  asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller idle, command accepted when cmd_valid & cmd_ready at a rising edge
- cmd_clear  in  1  clear register (overrides cmd_load)
- cmd_load  in  1  parallel-load cmd_data before shifting
- cmd_data  in  8  load value
- cmd_dir  in  1  1 = shift toward bit0 (shifter load_left=1), 0 = rotate toward bit7
- cmd_asr  in  1  with cmd_dir=1: bit7 held (arithmetic); else bit7 takes old bit0 (rotate); ignored when cmd_dir=0
- cmd_count  in  3  shift cycles, 0..7
- busy  out  1  command in progress (= !cmd_ready)
- result  out  8  Q captured at end of last command
- result_valid  out  1  one-cycle pulse when result updates
- sh_reset_n  out  1  to shifter reset_n
- sh_load_n  out  1  to shifter parallel_load_n
- sh_left  out  1  to shifter load_left
- sh_asr  out  1  to shifter ASRight
- sh_data  out  8  to shifter data_in
- sh_q  in  8  shifter Q

## Operation
- States: IDLE, CLEAR, LOAD, SHIFT, CAPTURE.
- On acceptance, register dir, asr, count, and data.
  - cmd_clear=1: go to CLEAR.
  - Else cmd_load=1: go to LOAD.
  - Else count>0: go to SHIFT.
  - Else: go to CAPTURE.
- IDLE and CAPTURE (hold): sh_reset_n=1, sh_load_n=0, sh_data=sh_q (combinational feedback), so the shifter reloads itself.
- CLEAR: sh_reset_n=0 for one cycle, then CAPTURE. Count, dir, and data are ignored.
- LOAD: sh_reset_n=1, sh_load_n=0, sh_data=latched data for one cycle. Next state is SHIFT if count>0, else CAPTURE.
- SHIFT: sh_load_n=1, sh_left=dir, sh_asr=asr. Lasts exactly count cycles, with a down-counter loaded at entry. Then CAPTURE.
- CAPTURE: at the closing edge, result<=sh_q and result_valid<=1 for one cycle; state goes to IDLE.
- sh_left and sh_asr are don't-care outside SHIFT; drive them 0.
- cmd_ready=(state==IDLE). A new command may be accepted in the same cycle result_valid is high.
- Inputs other than cmd_valid are sampled only at the accept edge; later changes have no effect.

## Timing
Accept edge is E0.
- Shifter updates:
  - Load/clear happens at E1.
  - Shifts happen at E(1+k) for k=1..count, or at E1..E(count) when there is no load.
- result_valid rises after the CAPTURE edge:
  - load or clear, count N: at E(2+N). Clear always uses E2.
  - no load: at E(1+N).
  - no load with N=0: at E1.
- Throughput: one command per latency+1 cycles.
- Reset asserted (async, any state):
  - Immediately: state=IDLE, cmd_ready=1, busy=0, result=0x00, result_valid=0, sh_load_n=1.
  - sh_reset_n=0 while reset is high (combinational OR), so the shifter clears at the next edge.
  - An in-flight command is dropped; no result_valid is produced.
- First cycle after reset deasserts: IDLE hold.

## Test plan
- Load 0x81, dir=1, asr=0, count=1 -> result=0xC0, result_valid 3 edges after accept, single-cycle pulse.
- Load 0x90, dir=1, asr=1, count=3 -> result=0xF2 at E5; sh_q stays 0xF2 for 10 idle cycles (hold verified).
- Load 0x81, dir=0, count=2 -> 0x06. Then wait 5 idle cycles. Then no-load, dir=0, count=7 -> 0x03 at E8; cmd_ready low throughout.
- cmd_clear=1 with cmd_load=1, data 0xFF, count 5 -> result=0x00 at E2; sh_load_n never low with 0xFF.
- Back-to-back: cmd_valid held high with two commands -> second accepted on the result_valid cycle; both results correct.
- Reset pulsed during SHIFT of count=7 -> outputs at reset values at once, sh_q=0x00 after next edge, no result_valid; a subsequent load 0x55, count 0 -> result 0x55.
